// File: rtl/operand_serializer_pkg.sv
// Shared types for the operand serializer slice:
// default data width, FSM state enum, operand-pair struct.
package challenge_pkg;

  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEND_B,
    SEND_C,
    GAP
  } ser_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] b;
    logic [DATA_W_DEF-1:0] c;
  } op_pair_t;

endpackage

// File: rtl/operand_serializer_if.sv
// Operand serializer bus: pair push handshake, serialized
// stream, status. master = upstream/driver, slave = serializer.
interface operand_serializer_if #(
  parameter int DATA_W = challenge_pkg::DATA_W_DEF
);
  logic              op_vld;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_c;
  logic              op_rdy;
  logic              arg_vld;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic [15:0]       sent_cnt;

  modport master (
    output op_vld, op_b, op_c,
    input  op_rdy, arg_vld, in_data, busy, sent_cnt
  );

  modport slave (
    input  op_vld, op_b, op_c,
    output op_rdy, arg_vld, in_data, busy, sent_cnt
  );
endinterface

// File: rtl/operand_serializer_fifo.sv
// op_pair_fifo: synchronous pair FIFO, registered full/empty.
// Ports: clk, rst (sync, low), push/wr_data, pop/rd_data, full, empty.
module op_pair_fifo
  import challenge_pkg::*;
#(
  parameter type T     = op_pair_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nx;
  logic          do_push;
  logic          do_pop;

  // A full FIFO never takes a push, even alongside a pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    cnt_nx = cnt;
    unique case (1'b1)
      do_push & ~do_pop: cnt_nx = cnt + 1'b1;
      do_pop & ~do_push: cnt_nx = cnt - 1'b1;
      default:           cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nx;
      full  <= (cnt_nx == (AW+1)'(DEPTH));
      empty <= (cnt_nx == '0);
    end
  end

endmodule

// File: rtl/operand_serializer.sv
// Serializes queued {b,c} pairs onto in_data with a low gap.
// Ports: clk, rst (sync, low), bus (slave: push, stream, status).
module operand_serializer
  import challenge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  operand_serializer_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } pair_t;

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  ser_state_t        state;
  logic [GW-1:0]     gap_q;
  logic              en_q;
  logic              vld_q;
  logic [DATA_W-1:0] dat_q;
  logic [15:0]       sent_q;

  pair_t wr_pair;
  pair_t head;
  logic  full;
  logic  empty;
  logic  pop;

  assign wr_pair = '{b: bus.op_b, c: bus.op_c};
  // Head leaves the FIFO on the SEND_C -> GAP edge.
  assign pop = (state == SEND_C);

  op_pair_fifo #(
    .T     (pair_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.op_vld & bus.op_rdy),
    .wr_data (wr_pair),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // en_q holds op_rdy low through reset and one edge after.
  assign bus.op_rdy   = en_q & ~full;
  assign bus.arg_vld  = vld_q;
  assign bus.in_data  = dat_q;
  assign bus.busy     = (state != IDLE) | ~empty;
  assign bus.sent_cnt = sent_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      gap_q  <= '0;
      en_q   <= 1'b0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
      sent_q <= '0;
    end else begin
      en_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state <= SEND_B;
            vld_q <= 1'b1;
            dat_q <= head.b;
          end
        end
        SEND_B: begin
          state <= SEND_C;
          dat_q <= head.c;
        end
        SEND_C: begin
          state  <= GAP;
          vld_q  <= 1'b0;
          dat_q  <= '0;
          gap_q  <= GW'(GAP_CYCLES - 1);
          sent_q <= sent_q + 1'b1;
        end
        GAP: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else if (!empty) begin
            state <= SEND_B;
            vld_q <= 1'b1;
            dat_q <= head.b;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: table, directed corners,
// random traffic against a stream-level reference model.
module tb_operand_serializer;
  import challenge_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } pair_s;

  typedef struct packed {
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [15:0]   cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  operand_serializer_if #(.DATA_W(DW)) bus ();

  operand_serializer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model: accepted pairs in order; stream phase.
  pair_s       q[$];
  logic [15:0] m_cnt     = '0;
  int          phase     = 0;
  int          low_run   = GAP;
  int          prev_pend = 0;
  bit          after_txn = 1'b0;
  logic        in_rst    = 1'b0;
  logic        exp_rdy;
  logic        exp_rise;
  logic        exp_busy;

  // Samples mid-low-phase; inputs for the next edge are stable.
  always @(negedge clk) begin
    #3;
    if (!in_rst) begin
      q.delete();
      m_cnt     = '0;
      phase     = 0;
      low_run   = GAP;
      prev_pend = 0;
      after_txn = 1'b0;
      exp_rdy   = 1'b0;
      chk("rst_vld", 64'(bus.arg_vld), 0);
      chk("rst_data", bus.in_data, 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_rdy", 64'(bus.op_rdy), 0);
      chk("rst_cnt", 64'(bus.sent_cnt), 0);
    end else begin
      if (phase == 2) begin
        chk("vld_after_c", 64'(bus.arg_vld), 0);
        chk("data_gap", bus.in_data, 0);
        m_cnt++;
        void'(q.pop_front());
        phase     = 0;
        low_run   = 1;
        after_txn = 1'b1;
      end else if (phase == 1) begin
        chk("vld_c", 64'(bus.arg_vld), 1);
        if (q.size() > 0)
          chk("data_c", bus.in_data, q[0].c);
        phase = 2;
      end else begin
        exp_rise = (prev_pend > 0) && (low_run >= GAP);
        chk("vld_low", 64'(bus.arg_vld), 64'(exp_rise));
        if (bus.arg_vld) begin
          if (q.size() > 0)
            chk("data_b", bus.in_data, q[0].b);
          phase = 1;
        end else begin
          chk("data_idle", bus.in_data, 0);
          low_run++;
        end
      end
      exp_busy = (phase != 0) || (q.size() > 0) ||
                 (after_txn && low_run <= GAP);
      exp_rdy  = (q.size() < DEPTH);
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      chk("op_rdy", 64'(bus.op_rdy), 64'(exp_rdy));
      chk("sent_cnt", 64'(bus.sent_cnt), 64'(m_cnt));
      prev_pend = q.size();
    end
    if (rst && bus.op_vld && exp_rdy)
      q.push_back('{b: bus.op_b, c: bus.op_c});
    in_rst = rst;
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      bus.op_vld = 1'b0;
      bus.op_b   = {$urandom, $urandom};
      bus.op_c   = {$urandom, $urandom};
    end
  endtask

  task automatic push_burst(int n, logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      bus.op_vld = 1'b1;
      bus.op_b   = base + 64'(2 * i);
      bus.op_c   = base + 64'(2 * i + 1);
    end
    idle(1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(2);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("drain_timeout", 64'(n < 300), 1);
  endtask

  vec_t tbl [6];
  int   acc;
  int   n;
  bit   saw_full;
  bit   saw_ffff;
  bit   saw_wrap;

  initial begin
    bus.op_vld = 1'b0;
    bus.op_b   = '0;
    bus.op_c   = '0;
    tbl[0] = '{b: 64'h1111, c: 64'h2222, cnt: 16'd1};
    tbl[1] = '{b: '1, c: '0, cnt: 16'd2};
    tbl[2] = '{b: '0, c: '1, cnt: 16'd3};
    tbl[3] = '{b: 64'hA5A5_A5A5_A5A5_A5A5,
               c: 64'h5A5A_5A5A_5A5A_5A5A, cnt: 16'd4};
    tbl[4] = '{b: 64'h8000_0000_0000_0001,
               c: 64'h1, cnt: 16'd5};
    tbl[5] = '{b: 64'hDEAD_BEEF, c: 64'hDEAD_BEEF,
               cnt: 16'd6};

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Single transactions from idle: exact latency and values.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      bus.op_vld = 1'b1;
      bus.op_b   = tbl[i].b;
      bus.op_c   = tbl[i].c;
      @(negedge clk);
      #1;
      bus.op_vld = 1'b0;
      bus.op_b   = {$urandom, $urandom};
      bus.op_c   = {$urandom, $urandom};
      #3 chk("t_accept_vld", 64'(bus.arg_vld), 0);
      @(negedge clk);
      #4;
      chk("t_b_vld", 64'(bus.arg_vld), 1);
      chk("t_b", bus.in_data, tbl[i].b);
      @(negedge clk);
      #4;
      chk("t_c_vld", 64'(bus.arg_vld), 1);
      chk("t_c", bus.in_data, tbl[i].c);
      @(negedge clk);
      #4;
      chk("t_end_vld", 64'(bus.arg_vld), 0);
      chk("t_cnt", 64'(bus.sent_cnt), 64'(tbl[i].cnt));
      idle(GAP + 1);
    end

    // Back-to-back pushes: gaps enforced by the model.
    push_burst(3, 64'h100);
    drain();
    chk("b2b_cnt", 64'(bus.sent_cnt), 9);

    // Overfill with op_vld held high.
    acc      = 0;
    n        = 0;
    saw_full = 1'b0;
    while (acc < DEPTH + 2 && n < 200) begin
      @(negedge clk);
      #1;
      bus.op_vld = 1'b1;
      bus.op_b   = 64'h200 + 64'(2 * acc);
      bus.op_c   = 64'h201 + 64'(2 * acc);
      #1;
      if (bus.op_rdy) acc++;
      else saw_full = 1'b1;
      n++;
    end
    chk("full_push_timeout", 64'(n < 200), 1);
    chk("full_seen", 64'(saw_full), 1);
    drain();
    chk("full_cnt", 64'(bus.sent_cnt), 64'(9 + DEPTH + 2));

    // Reset while c of the first of three pairs is on the bus.
    push_burst(3, 64'h300);
    n = 0;
    while (!(bus.arg_vld && bus.in_data == 64'h301)
           && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("wait_c_timeout", 64'(n < 50), 1);
    rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #3;
    chk("abort_vld", 64'(bus.arg_vld), 0);
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_cnt", 64'(bus.sent_cnt), 0);
    idle(12);
    chk("abort_quiet", 64'(bus.arg_vld), 0);

    // Counter wrap from a preloaded value.
    @(negedge clk);
    #1;
    force dut.sent_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1 release dut.sent_q;
    push_burst(3, 64'h400);
    saw_ffff = 1'b0;
    saw_wrap = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      #4;
      if (bus.sent_cnt == 16'hFFFF) saw_ffff = 1'b1;
      if (saw_ffff && bus.sent_cnt == 16'h0000)
        saw_wrap = 1'b1;
      n++;
    end
    chk("wrap_ffff", 64'(saw_ffff), 1);
    chk("wrap_zero", 64'(saw_wrap), 1);
    chk("wrap_cnt", 64'(bus.sent_cnt), 1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      bus.op_vld = ($urandom_range(0, 99) < 40);
      bus.op_b   = {$urandom, $urandom};
      bus.op_c   = {$urandom, $urandom};
    end
    drain();
    chk("final_cnt", 64'(bus.sent_cnt), 64'(m_cnt));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
